// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: iterative multiply/divide unit beside the EX stage.
// One operation per start handshake in IDLE: shift-add MUL or restoring
// shift-subtract DIV over WIDTH iterations, then a sign fixup cycle and a
// one-cycle done pulse. While an operation is running, stall holds the pipeline.
//
// Optional feature macro: MULDIV_EARLY_OUT_EN (MUL leaves CALC as soon as the
// remaining multiplier bits are zero; the fixup cycle realigns the product).
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   start, op, sgn       request (sampled in IDLE), 0=MUL/1=DIV, signed mode
//   op_a, op_b           multiplicand/dividend, multiplier/divisor
//   flush                synchronous abort of a running operation
//   busy, done           state != IDLE, one-cycle completion pulse
//   stall                combinational: start | (busy & ~done)
//   result_hi/result_lo  MUL product halves, or DIV remainder/quotient
//   div_zero             DIV with a zero divisor
module muldiv_sequencer #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic             sgn,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] result_hi,
    output logic [WIDTH-1:0] result_lo,
    output logic             div_zero
);

    localparam int unsigned PW = 2 * WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               op_q, op_d;
    logic               neg_lo_q, neg_lo_d;
    logic               neg_hi_q, neg_hi_d;
    logic [WIDTH-1:0]   acc_q, acc_d;       // MUL upper accumulator / DIV remainder
    logic [WIDTH-1:0]   shr_q, shr_d;       // MUL multiplier+low product / DIV quotient
    logic [WIDTH-1:0]   opnd_q, opnd_d;     // MUL multiplicand / DIV divisor magnitude
    logic [WIDTH-1:0]   a_orig_q, a_orig_d;
    logic [WIDTH-1:0]   res_hi_q, res_hi_d;
    logic [WIDTH-1:0]   res_lo_q, res_lo_d;
    logic               dz_q, dz_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
`ifdef MULDIV_EARLY_OUT_EN
    logic [WIDTH-1:0]   mrem_q, mrem_d;     // multiplier bits not yet consumed
`endif

    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     div_trial;
    logic [PW-1:0]      mul_raw, mul_fix;
    logic               calc_last;

    assign abs_a = (sgn && op_a[WIDTH-1]) ? WIDTH'(0) - op_a : op_a;
    assign abs_b = (sgn && op_b[WIDTH-1]) ? WIDTH'(0) - op_b : op_b;

    assign mul_sum   = {1'b0, acc_q} + (shr_q[0] ? {1'b0, opnd_q} : '0);
    assign rem_sh    = {acc_q, shr_q[WIDTH-1]};
    // rem_sh < 2*divisor, so bit WIDTH of the difference is a true sign bit
    assign div_trial = rem_sh - {1'b0, opnd_q};

`ifdef MULDIV_EARLY_OUT_EN
    assign calc_last = (cnt_q == CNT_W'(WIDTH - 1)) ||
                       (!op_q && (mrem_q[WIDTH-1:1] == '0));
    // Skipped iterations would only have shifted right; apply them at once
    assign mul_raw   = {acc_q, shr_q} >> (CNT_W'(WIDTH) - cnt_q);
`else
    assign calc_last = (cnt_q == CNT_W'(WIDTH - 1));
    assign mul_raw   = {acc_q, shr_q};
`endif
    assign mul_fix   = neg_lo_q ? PW'(0) - mul_raw : mul_raw;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start && !flush) state_d = S_CALC;
            S_CALC:  if (flush) state_d = S_IDLE;
                     else if (calc_last) state_d = S_FIXUP;
            S_FIXUP: state_d = flush ? S_IDLE : S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        cnt_d    = cnt_q;
        op_d     = op_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        acc_d    = acc_q;
        shr_d    = shr_q;
        opnd_d   = opnd_q;
        a_orig_d = a_orig_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        dz_d     = dz_q;
        busy_d   = (state_d != S_IDLE);
        done_d   = 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
        mrem_d   = mrem_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start && !flush) begin
                    op_d     = op;
                    cnt_d    = '0;
                    acc_d    = '0;
                    a_orig_d = op_a;
                    neg_lo_d = sgn & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                    neg_hi_d = sgn & op & op_a[WIDTH-1];
                    opnd_d   = op ? abs_b : abs_a;
                    shr_d    = op ? abs_a : abs_b;
`ifdef MULDIV_EARLY_OUT_EN
                    mrem_d   = abs_b;
`endif
                end
            end
            S_CALC: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (!op_q) begin
                    acc_d = mul_sum[WIDTH:1];
                    shr_d = {mul_sum[0], shr_q[WIDTH-1:1]};
`ifdef MULDIV_EARLY_OUT_EN
                    mrem_d = mrem_q >> 1;
`endif
                end else if (!div_trial[WIDTH]) begin
                    acc_d = div_trial[WIDTH-1:0];
                    shr_d = {shr_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = rem_sh[WIDTH-1:0];
                    shr_d = {shr_q[WIDTH-2:0], 1'b0};
                end
            end
            S_FIXUP: begin
                if (!flush) begin
                    done_d = 1'b1;
                    if (!op_q) begin
                        res_hi_d = mul_fix[PW-1:WIDTH];
                        res_lo_d = mul_fix[WIDTH-1:0];
                        dz_d     = 1'b0;
                    end else if (opnd_q == '0) begin
                        res_hi_d = a_orig_q;
                        res_lo_d = '1;
                        dz_d     = 1'b1;
                    end else begin
                        res_hi_d = neg_hi_q ? WIDTH'(0) - acc_q : acc_q;
                        res_lo_d = neg_lo_q ? WIDTH'(0) - shr_q : shr_q;
                        dz_d     = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            op_q     <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            acc_q    <= '0;
            shr_q    <= '0;
            opnd_q   <= '0;
            a_orig_q <= '0;
            res_hi_q <= '0;
            res_lo_q <= '0;
            dz_q     <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
            mrem_q   <= '0;
`endif
        end else begin
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            acc_q    <= acc_d;
            shr_q    <= shr_d;
            opnd_q   <= opnd_d;
            a_orig_q <= a_orig_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            dz_q     <= dz_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef MULDIV_EARLY_OUT_EN
            mrem_q   <= mrem_d;
`endif
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result_hi = res_hi_q;
    assign result_lo = res_lo_q;
    assign div_zero  = dz_q;
    assign stall     = start | (busy_q & ~done_q);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: arithmetic vectors, latency, stall,
// flush, mid-operation reset and ignored start requests.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, op, sgn, flush;
    logic [15:0] op_a, op_b;
    logic        busy, done, stall, div_zero;
    logic [15:0] result_hi, result_lo;

    int pass_cnt  = 0;
    int total_cnt = 0;

    localparam int LAT_FULL = 17;
`ifdef MULDIV_EARLY_OUT_EN
    localparam int LAT_B5  = 4;
    localparam int LAT_B16 = 6;
`else
    localparam int LAT_B5  = 17;
    localparam int LAT_B16 = 17;
`endif

    muldiv_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .sgn(sgn),
        .op_a(op_a), .op_b(op_b), .flush(flush),
        .busy(busy), .done(done), .stall(stall),
        .result_hi(result_hi), .result_lo(result_lo), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one request and waits (bounded) for done; lat counts edges after accept
    task automatic run_op(input logic o, input logic s, input logic [15:0] a,
                          input logic [15:0] b, output int lat, output bit stall_ok);
        op = o; sgn = s; op_a = a; op_b = b; start = 1'b1;
        #1;
        stall_ok = (stall === 1'b1);
        tick();
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (stall !== 1'b1) stall_ok = 1'b0;
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; op = 1'b0; sgn = 1'b0; flush = 1'b0;
        op_a = '0; op_b = '0;
        repeat (3) tick();
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else pass_cnt++;
        total_cnt++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else pass_cnt++;
        total_cnt++; if (stall !== 1'b0) $display("FAIL reset_stall got %b exp 0", stall); else pass_cnt++;
        total_cnt++; if ({result_hi, result_lo} !== 32'h0) $display("FAIL reset_result got %h exp 0", {result_hi, result_lo}); else pass_cnt++;
        total_cnt++; if (div_zero !== 1'b0) $display("FAIL reset_dz got %b exp 0", div_zero); else pass_cnt++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_mul_signed();
        int lat; bit sok;
        run_op(1'b0, 1'b1, 16'hFFFD, 16'd5, lat, sok);
        total_cnt++; if (lat !== LAT_B5) $display("FAIL mul_s_lat got %0d exp %0d", lat, LAT_B5); else pass_cnt++;
        total_cnt++; if (sok !== 1'b1) $display("FAIL mul_s_stall got %b exp 1", sok); else pass_cnt++;
        total_cnt++; if (result_hi !== 16'hFFFF) $display("FAIL mul_s_hi got %h exp FFFF", result_hi); else pass_cnt++;
        total_cnt++; if (result_lo !== 16'hFFF1) $display("FAIL mul_s_lo got %h exp FFF1", result_lo); else pass_cnt++;
        total_cnt++; if (div_zero !== 1'b0) $display("FAIL mul_s_dz got %b exp 0", div_zero); else pass_cnt++;
        total_cnt++; if (stall !== 1'b0) $display("FAIL mul_s_stall_done got %b exp 0", stall); else pass_cnt++;
        tick();
        total_cnt++; if (done !== 1'b0) $display("FAIL mul_s_done_pulse got %b exp 0", done); else pass_cnt++;
        total_cnt++; if (busy !== 1'b0) $display("FAIL mul_s_idle got %b exp 0", busy); else pass_cnt++;
    endtask

    task automatic test_mul_unsigned();
        int lat; bit sok;
        run_op(1'b0, 1'b0, 16'hFFFF, 16'hFFFF, lat, sok);
        total_cnt++; if (lat !== LAT_FULL) $display("FAIL mul_u_lat got %0d exp %0d", lat, LAT_FULL); else pass_cnt++;
        total_cnt++; if ({result_hi, result_lo} !== 32'hFFFE_0001) $display("FAIL mul_u_res got %h exp FFFE0001", {result_hi, result_lo}); else pass_cnt++;
        tick();
        run_op(1'b0, 1'b0, 16'h1234, 16'h0010, lat, sok);
        total_cnt++; if (lat !== LAT_B16) $display("FAIL mul_u16_lat got %0d exp %0d", lat, LAT_B16); else pass_cnt++;
        total_cnt++; if ({result_hi, result_lo} !== 32'h0001_2340) $display("FAIL mul_u16_res got %h exp 00012340", {result_hi, result_lo}); else pass_cnt++;
        tick();
    endtask

    task automatic test_div_signed();
        int lat; bit sok;
        run_op(1'b1, 1'b1, 16'hFFF9, 16'd2, lat, sok);
        total_cnt++; if (lat !== LAT_FULL) $display("FAIL div_s_lat got %0d exp %0d", lat, LAT_FULL); else pass_cnt++;
        total_cnt++; if ({result_hi, result_lo} !== 32'hFFFF_FFFD) $display("FAIL div_s_res got %h exp FFFFFFFD", {result_hi, result_lo}); else pass_cnt++;
        tick();
        run_op(1'b1, 1'b1, 16'd7, 16'hFFFE, lat, sok);
        total_cnt++; if ({result_hi, result_lo} !== 32'h0001_FFFD) $display("FAIL div_s2_res got %h exp 0001FFFD", {result_hi, result_lo}); else pass_cnt++;
        tick();
        run_op(1'b1, 1'b1, 16'h8000, 16'hFFFF, lat, sok);
        total_cnt++; if ({result_hi, result_lo} !== 32'h0000_8000) $display("FAIL div_ovf_res got %h exp 00008000", {result_hi, result_lo}); else pass_cnt++;
        total_cnt++; if (div_zero !== 1'b0) $display("FAIL div_ovf_dz got %b exp 0", div_zero); else pass_cnt++;
        tick();
    endtask

    task automatic test_div_zero();
        int lat; bit sok;
        run_op(1'b1, 1'b0, 16'h1234, 16'h0000, lat, sok);
        total_cnt++; if (lat !== LAT_FULL) $display("FAIL dz_lat got %0d exp %0d", lat, LAT_FULL); else pass_cnt++;
        total_cnt++; if ({result_hi, result_lo} !== 32'h1234_FFFF) $display("FAIL dz_res got %h exp 1234FFFF", {result_hi, result_lo}); else pass_cnt++;
        total_cnt++; if (div_zero !== 1'b1) $display("FAIL dz_flag got %b exp 1", div_zero); else pass_cnt++;
        tick();
        run_op(1'b1, 1'b0, 16'd100, 16'd7, lat, sok);
        total_cnt++; if ({result_hi, result_lo} !== 32'h0002_000E) $display("FAIL div_u_res got %h exp 0002000E", {result_hi, result_lo}); else pass_cnt++;
        total_cnt++; if (div_zero !== 1'b0) $display("FAIL div_u_dz got %b exp 0", div_zero); else pass_cnt++;
        tick();
    endtask

    task automatic test_flush();
        bit saw_done = 1'b0;
        op = 1'b0; sgn = 1'b0; op_a = 16'd3; op_b = 16'hFFFF; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        total_cnt++; if (busy !== 1'b0) $display("FAIL flush_busy got %b exp 0", busy); else pass_cnt++;
        total_cnt++; if (stall !== 1'b0) $display("FAIL flush_stall got %b exp 0", stall); else pass_cnt++;
        repeat (25) begin
            tick();
            if (done === 1'b1) saw_done = 1'b1;
        end
        total_cnt++; if (saw_done !== 1'b0) $display("FAIL flush_no_done got %b exp 0", saw_done); else pass_cnt++;
        total_cnt++; if ({result_hi, result_lo} !== 32'h0002_000E) $display("FAIL flush_hold got %h exp 0002000E", {result_hi, result_lo}); else pass_cnt++;
        // flush in IDLE blocks acceptance of a simultaneous start
        start = 1'b1; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        total_cnt++; if (busy !== 1'b0) $display("FAIL idle_flush_busy got %b exp 0", busy); else pass_cnt++;
        tick();
    endtask

    task automatic test_restart();
        int lat = 0;
        int n = 0;
        op = 1'b0; sgn = 1'b0; op_a = 16'd3; op_b = 16'hFFFF; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) begin tick(); lat++; end
        op_a = 16'd100; op_b = 16'd100; start = 1'b1;
        tick(); lat++;
        start = 1'b0;
        while (done !== 1'b1 && lat < 40) begin tick(); lat++; end
        total_cnt++; if (lat !== LAT_FULL) $display("FAIL restart_lat got %0d exp %0d", lat, LAT_FULL); else pass_cnt++;
        total_cnt++; if ({result_hi, result_lo} !== 32'h0002_FFFD) $display("FAIL restart_res got %h exp 0002FFFD", {result_hi, result_lo}); else pass_cnt++;
        // start raised in the done cycle is not accepted
        op_a = 16'd4; op_b = 16'd4; start = 1'b1;
        #1;
        total_cnt++; if (stall !== 1'b1) $display("FAIL done_start_stall got %b exp 1", stall); else pass_cnt++;
        tick();
        total_cnt++; if (busy !== 1'b0) $display("FAIL done_start_busy got %b exp 0", busy); else pass_cnt++;
        tick();
        start = 1'b0;
        total_cnt++; if (busy !== 1'b1) $display("FAIL reissue_busy got %b exp 1", busy); else pass_cnt++;
        while (done !== 1'b1 && n < 40) begin tick(); n++; end
        total_cnt++; if ({result_hi, result_lo} !== 32'h0000_0010) $display("FAIL reissue_res got %h exp 00000010", {result_hi, result_lo}); else pass_cnt++;
        tick();
    endtask

    task automatic test_rst_mid();
        op = 1'b1; sgn = 1'b0; op_a = 16'd1000; op_b = 16'd3; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        total_cnt++; if (busy !== 1'b1) $display("FAIL rst_mid_pre got %b exp 1", busy); else pass_cnt++;
        rst = 1'b1;
        #1;
        total_cnt++; if (busy !== 1'b0) $display("FAIL rst_mid_busy got %b exp 0", busy); else pass_cnt++;
        total_cnt++; if ({result_hi, result_lo} !== 32'h0) $display("FAIL rst_mid_res got %h exp 0", {result_hi, result_lo}); else pass_cnt++;
        tick();
        rst = 1'b0;
        repeat (20) tick();
        total_cnt++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL rst_mid_after got done=%b busy=%b exp 0 0", done, busy); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_mul_signed();
        test_mul_unsigned();
        test_div_signed();
        test_div_zero();
        test_flush();
        test_restart();
        test_rst_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative 16-bit multiply/divide unit alongside the EX stage of the 16-bit pipelined datapath.
- Accepts one operation per start handshake and runs a shift-add (MUL) or restoring shift-subtract (DIV) loop over 16 cycles.
- Drives a stall request that holds the pipeline until the 32-bit result is ready for register writeback.

Parameters:
- WIDTH, 16, operand width. The result is 2*WIDTH bits. Only 16 is verified.
- CNT_W, 5, width of the iteration counter. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- start  input  1  request; sampled only in IDLE
- op  input  1  0 = MUL, 1 = DIV
- sgn  input  1  1 = two's-complement operands, 0 = unsigned
- op_a  input  16  multiplicand / dividend
- op_b  input  16  multiplier / divisor
- flush  input  1  synchronous abort from the hazard unit
- busy  output  1  high when state != IDLE
- done  output  1  one-cycle pulse; results valid
- stall  output  1  combinational: start | (busy & ~done)
- result_hi  output  16  MUL: product[31:16]; DIV: remainder
- result_lo  output  16  MUL: product[15:0]; DIV: quotient
- div_zero  output  1  registered; set at done when DIV has op_b == 0

Behaviour:
- Reset (async): state=IDLE, counter=0. busy, done, div_zero = 0. result_hi and result_lo = 0. All internal registers cleared.
- States: IDLE, CALC, FIXUP, DONE.
- IDLE, start=1 (accept edge E0):
  - latch op and sgn;
  - latch |op_a| and |op_b| (magnitudes when sgn=1);
  - latch the result sign: MUL a^b; DIV quotient a^b, remainder a;
  - counter=0, go to CALC.
- CALC: one iteration per clock. Counter increments. After the 16th iteration (edge E16), go to FIXUP.
- MUL iteration: if multiplier LSB is 1, add multiplicand to the upper accumulator (17-bit sum, carry kept); then shift {acc, multiplier} right by 1.
- DIV iteration: shift {rem, quo} left by 1; trial = rem - divisor (17-bit). If trial is non-negative, rem = trial and quo LSB = 1.
- FIXUP (edge E17): apply two's-complement negation where the latched sign requires it. Load result_hi and result_lo, set div_zero, go to DONE.
- DONE: done=1 for exactly one cycle (the cycle after E17). The next edge returns to IDLE.
- Latency: done is visible 17 edges after the accept edge. stall is high from the cycle start is first seen through E17; it drops in the done cycle.
- result_hi, result_lo and div_zero hold their values until the next FIXUP. They are not cleared on return to IDLE.
- start while busy: ignored; no queueing.
- start in the DONE cycle: ignored. The requester re-asserts in IDLE; stall covers this because start=1 forces stall.
- flush=1 in any non-IDLE state: next state is IDLE. No done pulse; results unchanged. flush in IDLE has no effect, and start is not accepted that edge.
- Divide by zero:
  - result_lo = 16'hFFFF, result_hi = op_a (original value), div_zero = 1;
  - latency unchanged;
  - sign fixup bypassed.
- Signed overflow, -32768 / -1: quotient 16'h8000, remainder 0, div_zero = 0.
- Signed division truncates toward zero. The remainder takes the sign of the dividend.
- Reset asserted mid-operation: immediate return to reset values; no done.

Optional Feature:
- Macro MULDIV_EARLY_OUT_EN.
- Defined: for MUL only, CALC exits to FIXUP after the first iteration that leaves the remaining multiplier bits zero. The accumulator is aligned by the outstanding shift count during FIXUP.
  - CALC cycles = max(1, msb_index(|op_b|) + 1); done follows at edge N+1.
  - op_b = 5 gives done after edge E4; op_b = 0 gives done after E2.
  - DIV is unaffected.
- Undefined: every operation takes exactly 16 CALC cycles, and done follows E17.

Test Plan:
- MUL sgn=1, a=16'hFFFD (-3), b=5 -> done at E17; hi=16'hFFFF, lo=16'hFFF1; div_zero=0; stall high for E0..E17.
- MUL sgn=0, a=b=16'hFFFF -> hi=16'hFFFE, lo=16'h0001; with MULDIV_EARLY_OUT_EN still at E17 (full-width multiplier).
- DIV sgn=1, a=-7 (16'hFFF9), b=2 -> lo=16'hFFFD (-3), hi=16'hFFFF (-1).
- DIV sgn=1, a=16'h8000, b=16'hFFFF -> lo=16'h8000, hi=0.
- DIV a=16'h1234, b=0 -> lo=16'hFFFF, hi=16'h1234, div_zero=1 at E17.
- Control:
  - start MUL, flush at E5 -> IDLE at E6, no done pulse, prior results held;
  - rst pulsed at E8 of a DIV -> busy=0 and outputs zero immediately;
  - start re-pulsed during CALC -> ignored.
